victim_tag_cam: RTL
===================

# victim_tag_cam

Parametrised, fully associative tag store for the victim cache. Holds `WAYS` tags with per-way valid bits, performs a single-cycle parallel compare against a lookup tag, and tracks replacement order so it can nominate the victim way for the next fill. It sits beside the victim-cache data array: the controller issues lookups and fills here, and uses `hit_way` and `victim_way` to index the data array.

## Interface
- `WAYS`, 4: number of ways; power of two, 2..16.
- `TAG_W`, 11: tag width in bits.
- `WAY_W`, $clog2(WAYS): way-index width; derived, not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `lookup_en`  in  1  qualifies `lookup_tag` and allows a hit to update replacement state.
- `lookup_tag`  in  TAG_W  tag to compare.
- `hit`  out  1  `lookup_en` and at least one valid way matches.
- `hit_way`  out  WAY_W  lowest-index matching valid way; 0 when `hit`=0.
- `multi_hit`  out  1  more than one valid way matches; error flag for the controller.
- `load`  in  1  write `load_tag` into `load_way` and set that way valid.
- `load_way`  in  WAY_W  target way of a fill; normally driven from `victim_way`.
- `load_tag`  in  TAG_W  tag to write.
- `inv`  in  1  clear the valid bit of `inv_way`.
- `inv_way`  in  WAY_W  way to invalidate.
- `victim_way`  out  WAY_W  way to replace on the next fill.
- `full`  out  1  all ways valid.
- `rd_way`  in  WAY_W  debug/writeback read index.
- `rd_tag`  out  TAG_W  tag stored in `rd_way`.
- `rd_valid`  out  1  valid bit of `rd_way`.

## Operation
- State: `tag[WAYS]`, `valid[WAYS]`, replacement state (age per way, WAY_W bits, or round-robin pointer; see Configuration).
- Compare: combinational over registered state; only valid ways can match.
- LRU update on a "touch" of way w: `age[w]`←0; every way with age < old `age[w]` increments; all others hold. The ages remain a permutation of 0..WAYS-1.
- Touch sources: `load` touches `load_way`; `lookup_en`&&`hit` touches `hit_way`.
- Victim: lowest-index invalid way if any; otherwise the way with age WAYS-1.
- `inv`: clears `valid[inv_way]`; leaves tag and age unchanged.
- Same-cycle priority:
  - `load` and lookup hit: only the `load` touch is applied.
  - `load` and `inv` to the same way: `load` wins, and the way ends valid.
  - `inv` and a lookup hit on the same way: the invalidate is applied, and the touch is still applied to the ages.
- Loading a tag already present in another way is not blocked. The controller must avoid it; `multi_hit` flags it on a later lookup.
- Reset (`rst_n`=0 at an edge):
  - All `valid`←0 and all `tag`←0.
  - `age[i]`←i, or the round-robin pointer←0.
  - Outputs after reset: `hit`=0, `hit_way`=0, `multi_hit`=0, `victim_way`=0, `full`=0, `rd_valid`=0, `rd_tag`=0.
  - Reset overrides any `load`, `inv` or lookup in the same cycle.

## Timing
- `hit`, `hit_way`, `multi_hit`, `rd_tag` and `rd_valid` are combinational from the inputs and registered state, giving a zero-cycle result.
- `victim_way` and `full` are functions of registered state only. They change one cycle after a `load`, `inv` or touch.
- A fill written at edge N is visible to lookups from cycle N+1. A same-cycle lookup of the tag being loaded misses.
- There is no handshake and no stall. Every request is accepted in the cycle it is asserted.

## Configuration
- `VC_TAG_TRUE_LRU_EN` defined:
  - Age-based true LRU as described above.
- `VC_TAG_TRUE_LRU_EN` not defined:
  - The age registers are not implemented. A WAY_W-bit round-robin pointer replaces them.
  - When no way is invalid, `victim_way` = pointer.
  - The pointer increments, wrapping at WAYS-1 to 0, on each `load` where `load_way` equals the pointer. Hits do not affect it.
  - The invalid-way-first rule still applies.

## Test plan
- Reset, then fill: after reset, `victim_way`=0 and `full`=0. Load tags 0x101, 0x102, 0x103, 0x104 each to `victim_way` -> they land in ways 0,1,2,3, then `full`=1 and `victim_way`=0.
- Hit/miss: with the fill above, lookup 0x103 -> `hit`=1, `hit_way`=2. Lookup 0x7FF -> `hit`=0, `hit_way`=0. With `lookup_en`=0, lookup 0x103 -> `hit`=0.
- LRU (true-LRU build): full array, hit way 0, then way 1 -> `victim_way`=2. Load 0x200 into way 2 -> `victim_way`=3.
- Invalidate: full array, `inv` way 2 -> the next cycle `full`=0, `victim_way`=2, and lookup 0x103 misses. `inv` way 1 plus `load` way 1 with 0x055 in the same cycle -> way 1 valid with tag 0x055.
- Duplicate: load 0x0AA into ways 1 and 3 -> lookup 0x0AA gives `hit_way`=1 and `multi_hit`=1.
- Mid-operation reset: assert `rst_n`=0 together with `load` way 0 tag 0x123 -> the next cycle lookup 0x123 misses, `rd_valid`=0 for way 0, and `victim_way`=0.

Source files
------------

// File: rtl/victim_tag_cam.sv
`default_nettype none
// ============================================================================
// Module   : victim_tag_cam
// Brief    : Fully associative tag store for the victim cache. Parallel
//            single-cycle tag compare, per-way valid bits and victim-way
//            nomination for the next fill.
//            Compile-time option VC_TAG_TRUE_LRU_EN selects age-based true
//            LRU; without it a round-robin pointer picks the victim.
// Revision : 1.0 - initial release
// ============================================================================
module victim_tag_cam #(
    parameter  int WAYS  = 4,
    parameter  int TAG_W = 11,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_en,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic             multi_hit,
    input  logic             load,
    input  logic [WAY_W-1:0] load_way,
    input  logic [TAG_W-1:0] load_tag,
    input  logic             inv,
    input  logic [WAY_W-1:0] inv_way,
    output logic [WAY_W-1:0] victim_way,
    output logic             full,
    input  logic [WAY_W-1:0] rd_way,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid
);

    localparam logic [WAY_W-1:0] c_OLDEST_AGE = WAY_W'(WAYS - 1);

    logic [TAG_W-1:0] r_tag   [WAYS];
    logic [WAYS-1:0]  r_valid;

    logic [WAYS-1:0]  w_match;
    logic             w_found;
    logic             w_multi;
    logic [WAY_W-1:0] w_first;
    logic             w_free_any;
    logic [WAY_W-1:0] w_free_way;
    logic [WAY_W-1:0] w_repl_way;

    // Per-way compare; only valid ways can match.
    for (genvar i = 0; i < WAYS; i++) begin : g_match
        assign w_match[i] = r_valid[i] && (r_tag[i] == lookup_tag);
    end

    // Priority-encode the lowest matching way and detect duplicate matches.
    always_comb begin
        w_found = 1'b0;
        w_multi = 1'b0;
        w_first = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_match[i]) begin
                if (w_found) begin
                    w_multi = 1'b1;
                end else begin
                    w_first = WAY_W'(i);
                end
                w_found = 1'b1;
            end
        end
    end

    assign hit       = lookup_en && w_found;
    assign hit_way   = hit ? w_first : '0;
    assign multi_hit = lookup_en && w_multi;

    // Lowest-index invalid way is always preferred for a fill.
    always_comb begin
        w_free_any = 1'b0;
        w_free_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!r_valid[i] && !w_free_any) begin
                w_free_any = 1'b1;
                w_free_way = WAY_W'(i);
            end
        end
    end

    assign victim_way = w_free_any ? w_free_way : w_repl_way;
    assign full       = &r_valid;
    assign rd_tag     = r_tag[rd_way];
    assign rd_valid   = r_valid[rd_way];

    // Tag and valid storage; a load to the same way as an invalidate wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < WAYS; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (inv) begin
                r_valid[inv_way] <= 1'b0;
            end
            if (load) begin
                r_valid[load_way] <= 1'b1;
                r_tag[load_way]   <= load_tag;
            end
        end
    end

`ifdef VC_TAG_TRUE_LRU_EN
    logic [WAY_W-1:0] r_age [WAYS];
    logic             w_touch;
    logic [WAY_W-1:0] w_touch_way;
    logic [WAY_W-1:0] w_touch_age;

    // A fill takes precedence over a lookup hit as the touch source.
    assign w_touch     = load || hit;
    assign w_touch_way = load ? load_way : hit_way;
    assign w_touch_age = r_age[w_touch_way];

    // The least recently used way carries the maximum age.
    always_comb begin
        w_repl_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_age[i] == c_OLDEST_AGE) begin
                w_repl_way = WAY_W'(i);
            end
        end
    end

    // Touched way becomes youngest; younger ways age by one, keeping a permutation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WAYS; i++) begin
                r_age[i] <= WAY_W'(i);
            end
        end else if (w_touch) begin
            for (int i = 0; i < WAYS; i++) begin
                if (WAY_W'(i) == w_touch_way) begin
                    r_age[i] <= '0;
                end else if (r_age[i] < w_touch_age) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end
`else
    logic [WAY_W-1:0] r_ptr;

    assign w_repl_way = r_ptr;

    // Pointer advances only when a fill consumes the way it nominates; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (load && (load_way == r_ptr)) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
